// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared forward-select encodings, tag constants and multiply FSM states
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_ZERO       = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_BUSY = 1'b1
  } multState_t;

endpackage

// File: rtl/hazard_scoreboard_stage_reg.sv
// rtl/hazard_scoreboard_stage_reg.sv - tracking register with synchronous reset, enable and clear
module hz_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over enable so a bubble can be inserted even while holding.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W tag tracking, D/E forwarding selects, stalls/flush and multiply occupancy
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MULT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] WriteRegD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  BranchD,
  input  logic                  MultD,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushE
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam int E_W   = 3 * REG_ADDR_W + 3;
  localparam int M_W   = REG_ADDR_W + 2;
  localparam int W_W   = REG_ADDR_W + 1;
  localparam logic [REG_ADDR_W-1:0] ZERO_TAG = REG_ADDR_W'(REG_ZERO);

  logic [REG_ADDR_W-1:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic                  RegWriteE, MemtoRegE, MultE;
  logic                  RegWriteM, MemtoRegM, RegWriteW;

  logic [E_W-1:0] eIn, eOut;
  logic [M_W-1:0] mIn, mOut;
  logic [W_W-1:0] wIn, wOut;

  multState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             busy, eLoad, lwStall, branchStall, stallAny;

  // A source tag of r0 never creates a dependency.
  function automatic logic tagHit(input logic [REG_ADDR_W-1:0] src,
                                  input logic [REG_ADDR_W-1:0] dst);
    return (src != ZERO_TAG) && (src == dst);
  endfunction

  assign eIn = {RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, MultD};
  assign {RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MultE} = eOut;
  assign mIn = {WriteRegE, RegWriteE, MemtoRegE};
  assign {WriteRegM, RegWriteM, MemtoRegM} = mOut;
  assign wIn = {WriteRegM, RegWriteM};
  assign {WriteRegW, RegWriteW} = wOut;

  hz_stage_reg #(.WIDTH(E_W)) uStageE (
    .clk(clk), .reset(reset), .en(!busy), .clr(FlushE), .d(eIn), .q(eOut)
  );

  // While the multiplier holds E, M receives bubbles.
  hz_stage_reg #(.WIDTH(M_W)) uStageM (
    .clk(clk), .reset(reset), .en(1'b1), .clr(busy), .d(mIn), .q(mOut)
  );

  hz_stage_reg #(.WIDTH(W_W)) uStageW (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(wIn), .q(wOut)
  );

  assign busy  = (state == MULT_BUSY) && MultE;
  assign eLoad = !busy && !FlushE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MULT_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The load cycle counts as the first of MULT_CYCLES spent in E.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      MULT_IDLE: begin
        if (eLoad && MultD && (MULT_CYCLES > 1)) begin
          stateNext = MULT_BUSY;
          cntNext   = CNT_W'(MULT_CYCLES - 1);
        end
      end
      MULT_BUSY: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = MULT_IDLE;
        end
      end
      default: begin
        stateNext = MULT_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign ForwardAD = RegWriteM && tagHit(RsD, WriteRegM);
  assign ForwardBD = RegWriteM && tagHit(RtD, WriteRegM);

  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && tagHit(RsE, WriteRegM)) begin
      ForwardAE = FWD_MEM;
    end else if (RegWriteW && tagHit(RsE, WriteRegW)) begin
      ForwardAE = FWD_WB;
    end
  end

  always_comb begin
    ForwardBE = FWD_RF;
    if (RegWriteM && tagHit(RtE, WriteRegM)) begin
      ForwardBE = FWD_MEM;
    end else if (RegWriteW && tagHit(RtE, WriteRegW)) begin
      ForwardBE = FWD_WB;
    end
  end

  assign lwStall = MemtoRegE && tagHit(RtE, RsD | ZERO_TAG) && (RtE == RsD)
                 || MemtoRegE && tagHit(RtE, RtD);

  assign branchStall = BranchD &&
                       ((RegWriteE && (tagHit(RsD, WriteRegE) || tagHit(RtD, WriteRegE))) ||
                        (MemtoRegM && (tagHit(RsD, WriteRegM) || tagHit(RtD, WriteRegM))));

  assign stallAny = lwStall || branchStall;

  // A busy multiplier holds F/D and E without inserting a bubble.
  assign StallF = busy || stallAny;
  assign StallD = busy || stallAny;
  assign FlushE = !busy && stallAny;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against a stage-list reference model
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] RsD, RtD, WriteRegD;
  logic          RegWriteD, MemtoRegD, BranchD, MultD;
  logic          ForwardAD, ForwardBD, StallF, StallD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;

  hazard_scoreboard #(.REG_ADDR_W(AW), .MULT_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .MultD(MultD),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, wd;
    bit rw, mr, mult;
  } instr_t;

  typedef struct {
    bit fad, fbd;
    int fae, fbe;
    bit sf, sd, fe;
  } exp_t;

  instr_t pipe[3];
  instr_t bubble;
  int     multLeft;
  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;

  instr_t curD;
  bit     curRst;
  exp_t   curExp;

  function automatic instr_t mk(int rs, int rt, int wd, bit rw, bit mr, bit mult);
    instr_t i;
    i.rs = rs; i.rt = rt; i.wd = wd; i.rw = rw; i.mr = mr; i.mult = mult;
    return i;
  endfunction

  function automatic bit same(int a, int r);
    return (r != 0) && (a == r);
  endfunction

  function automatic bit feeds(instr_t s, int r);
    return s.rw && same(s.wd, r);
  endfunction

  function automatic int selE(int src);
    if (feeds(pipe[1], src)) return 2;
    if (feeds(pipe[2], src)) return 1;
    return 0;
  endfunction

  function automatic exp_t predict(instr_t d, bit br);
    exp_t e;
    bit lw, bs;
    e.fad = feeds(pipe[1], d.rs);
    e.fbd = feeds(pipe[1], d.rt);
    e.fae = selE(pipe[0].rs);
    e.fbe = selE(pipe[0].rt);
    lw = pipe[0].mr && (same(d.rs, pipe[0].rt) || same(d.rt, pipe[0].rt));
    bs = br && (feeds(pipe[0], d.rs) || feeds(pipe[0], d.rt) ||
                (pipe[1].mr && (same(pipe[1].wd, d.rs) || same(pipe[1].wd, d.rt))));
    if (multLeft > 0) begin
      e.sf = 1; e.sd = 1; e.fe = 0;
    end else begin
      e.sf = lw | bs; e.sd = lw | bs; e.fe = lw | bs;
    end
    return e;
  endfunction

  task automatic advance(instr_t d, bit rst, bit flush);
    if (rst) begin
      pipe[0] = bubble; pipe[1] = bubble; pipe[2] = bubble;
      multLeft = 0;
    end else begin
      pipe[2] = pipe[1];
      if (multLeft > 0) begin
        pipe[1] = bubble;
        multLeft--;
      end else begin
        pipe[1] = pipe[0];
        if (flush) begin
          pipe[0] = bubble;
        end else begin
          pipe[0] = d;
          if (d.mult) multLeft = MC - 1;
        end
      end
    end
  endtask

  task automatic cycle(instr_t d, bit br, bit rst);
    @(posedge clk);
    advance(curD, curRst, curExp.fe);
    #1;
    curD = d; curRst = rst;
    reset = rst;
    RsD = AW'(d.rs); RtD = AW'(d.rt); WriteRegD = AW'(d.wd);
    RegWriteD = d.rw; MemtoRegD = d.mr; MultD = d.mult; BranchD = br;
    curExp = predict(d, br);
    q.push_back(curExp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ForwardAD", 32'(ForwardAD), 32'(e.fad));
      chk("ForwardBD", 32'(ForwardBD), 32'(e.fbd));
      chk("ForwardAE", 32'(ForwardAE), e.fae);
      chk("ForwardBE", 32'(ForwardBE), e.fbe);
      chk("StallF", 32'(StallF), 32'(e.sf));
      chk("StallD", 32'(StallD), 32'(e.sd));
      chk("FlushE", 32'(FlushE), 32'(e.fe));
    end
  end

  initial begin
    instr_t nop;
    bubble = mk(0, 0, 0, 0, 0, 0);
    nop = bubble;
    pipe[0] = bubble; pipe[1] = bubble; pipe[2] = bubble;
    multLeft = 0;
    curD = bubble; curRst = 1; curExp = '{default: 0};
    reset = 1; RsD = '0; RtD = '0; WriteRegD = '0;
    RegWriteD = 0; MemtoRegD = 0; BranchD = 0; MultD = 0;

    cycle(nop, 0, 1);
    cycle(nop, 0, 1);
    cycle(nop, 0, 0);

    // M writes r3, branch reads r5/r3
    cycle(mk(0, 0, 3, 1, 0, 0), 0, 0);
    cycle(nop, 0, 0);
    cycle(mk(5, 3, 0, 0, 0, 0), 1, 0);

    // load-use stall, then W forwarding
    cycle(mk(0, 0, 2, 1, 1, 0), 0, 0);
    cycle(mk(2, 0, 6, 1, 0, 0), 0, 0);
    cycle(mk(2, 0, 6, 1, 0, 0), 0, 0);
    cycle(nop, 0, 0);
    cycle(nop, 0, 0);

    // branch stalls on E writer and on M load
    cycle(mk(0, 0, 4, 1, 0, 0), 0, 0);
    cycle(mk(4, 0, 0, 0, 0, 0), 1, 0);
    cycle(mk(4, 0, 0, 0, 0, 0), 1, 0);
    cycle(mk(0, 0, 4, 1, 1, 0), 0, 0);
    cycle(nop, 0, 0);
    cycle(mk(4, 0, 0, 0, 0, 0), 1, 0);
    cycle(nop, 0, 0);

    // multiply occupancy
    cycle(mk(1, 2, 9, 1, 0, 1), 0, 0);
    for (int i = 0; i < 6; i++) cycle(mk(9, 0, 10, 1, 0, 0), 0, 0);
    cycle(nop, 0, 0);

    // r0 never matches
    cycle(mk(0, 0, 0, 1, 0, 0), 0, 0);
    cycle(nop, 0, 0);
    cycle(mk(0, 0, 0, 0, 0, 0), 1, 0);

    // M and W both write r7
    cycle(mk(0, 0, 7, 1, 0, 0), 0, 0);
    cycle(mk(0, 0, 7, 1, 0, 0), 0, 0);
    cycle(mk(7, 7, 0, 0, 0, 0), 0, 0);
    cycle(nop, 0, 0);

    // reset mid-multiply
    cycle(mk(0, 0, 0, 0, 0, 1), 0, 0);
    cycle(nop, 0, 0);
    cycle(nop, 0, 1);
    cycle(nop, 0, 0);
    cycle(nop, 0, 0);

    for (int i = 0; i < 600; i++) begin
      instr_t r;
      bit mr, br, rst;
      mr = ($urandom_range(0, 4) == 0);
      r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             mr | bit'($urandom_range(0, 1)), mr, !mr && ($urandom_range(0, 19) == 0));
      br = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle(r, br, rst);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
